// File: rtl/channel_refresh_scheduler.sv
// Per-channel DDR4 refresh scheduler: per-rank tREFI/debt tracking, rank fencing, PREA+REF issue.
// Optional feature macro: REFRESH_STAGGER_EN spreads the per-rank tREFI expiries after reset.
module channel_refresh_scheduler #(
  parameter int unsigned NUMRANK = 4,
  parameter int unsigned TREFI   = 7800,
  parameter int unsigned TRP     = 16,
  parameter int unsigned TRFC    = 256,
  parameter int unsigned URGENT  = 4,
  parameter int unsigned MAXDEBT = 8,
  localparam int unsigned RW     = (NUMRANK > 1) ? $clog2(NUMRANK) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               refresh_en,
  input  logic [NUMRANK-1:0] rank_busy,
  output logic [NUMRANK-1:0] ref_fence,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [RW-1:0]      cmd_rank,
  output logic [NUMRANK-1:0] ref_active,
  output logic               ref_overflow
);

  localparam int unsigned CW   = (TREFI > 1) ? $clog2(TREFI) : 1;
  localparam int unsigned DW   = $clog2(MAXDEBT + 1);
  localparam int unsigned TMAX = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned WW   = (TMAX > 1) ? $clog2(TMAX) : 1;
`ifdef REFRESH_STAGGER_EN
  localparam int unsigned STAGGER = TREFI / NUMRANK;
`else
  localparam int unsigned STAGGER = 0;
`endif

  typedef enum logic [2:0] {StIdle, StPre, StWaitRp, StRef, StWaitRfc} state_e;

  state_e             state_q, state_d;
  logic [RW-1:0]      rank_q, rank_d, ptr_q, ptr_d, sel, cmd_rank_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [CW-1:0]      refi_q [NUMRANK];
  logic [CW-1:0]      refi_d [NUMRANK];
  logic [DW-1:0]      debt_q [NUMRANK];
  logic [DW-1:0]      debt_d [NUMRANK];
  logic [NUMRANK-1:0] expire, eligible, fence_d, active_d;
  logic               sel_found, ref_dec, valid_d, ovf_d;
  logic [1:0]         op_d;

  always_comb begin
    for (int r = 0; r < NUMRANK; r++) begin
      expire[r] = refresh_en && (refi_q[r] == '0);
      refi_d[r] = refi_q[r];
      if (refresh_en) refi_d[r] = expire[r] ? CW'(TREFI - 1) : refi_q[r] - CW'(1);
      eligible[r] = (debt_q[r] != '0) && (!rank_busy[r] || (debt_q[r] >= DW'(URGENT)));
    end
  end

  // Scan downwards so the eligible rank closest after the pointer wins.
  always_comb begin : p_rr
    logic [RW-1:0] idx;
    idx       = '0;
    sel_found = 1'b0;
    sel       = ptr_q;
    for (int i = NUMRANK - 1; i >= 0; i--) begin
      idx = RW'((int'(ptr_q) + i) % NUMRANK);
      if (eligible[idx]) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    valid_d = cmd_valid;
    ref_dec = 1'b0;
    case (state_q)
      StIdle: begin
        if (refresh_en && sel_found) begin
          state_d = StPre;
          rank_d  = sel;
          valid_d = !rank_busy[sel];
          ptr_d   = (int'(sel) == NUMRANK - 1) ? '0 : sel + RW'(1);
        end
      end
      StPre: begin
        if (cmd_valid) begin
          if (cmd_ready) begin
            valid_d = 1'b0;
            wait_d  = WW'(TRP - 1);
            state_d = StWaitRp;
          end
        end else if (!rank_busy[rank_q]) begin
          valid_d = 1'b1;
        end
      end
      StWaitRp: begin
        if (wait_q == '0) begin
          state_d = StRef;
          valid_d = 1'b1;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      StRef: begin
        if (cmd_valid && cmd_ready) begin
          valid_d = 1'b0;
          ref_dec = 1'b1;
          wait_d  = WW'(TRFC - 1);
          state_d = StWaitRfc;
        end
      end
      StWaitRfc: begin
        if (wait_q == '0) state_d = StIdle;
        else              wait_d  = wait_q - WW'(1);
      end
      default: state_d = StIdle;
    endcase

    op_d       = 2'b00;
    cmd_rank_d = '0;
    if (valid_d) begin
      op_d       = (state_d == StRef) ? 2'b10 : 2'b01;
      cmd_rank_d = rank_d;
    end
  end

  // A same-cycle expiry and REF decrement on one rank cancel out.
  always_comb begin : p_debt
    logic dec;
    dec   = 1'b0;
    ovf_d = ref_overflow;
    for (int r = 0; r < NUMRANK; r++) begin
      dec       = ref_dec && (int'(rank_q) == r);
      debt_d[r] = debt_q[r];
      if (expire[r] && !dec) begin
        if (debt_q[r] == DW'(MAXDEBT)) ovf_d     = 1'b1;
        else                           debt_d[r] = debt_q[r] + DW'(1);
      end else if (dec && !expire[r]) begin
        debt_d[r] = debt_q[r] - DW'(1);
      end
      fence_d[r]  = (debt_d[r] >= DW'(URGENT)) ||
                    ((state_d != StIdle) && (int'(rank_d) == r));
      active_d[r] = (state_d inside {StWaitRp, StRef, StWaitRfc}) && (int'(rank_d) == r);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rank_q       <= '0;
      ptr_q        <= '0;
      wait_q       <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= 2'b00;
      cmd_rank     <= '0;
      ref_fence    <= '0;
      ref_active   <= '0;
      ref_overflow <= 1'b0;
      for (int r = 0; r < NUMRANK; r++) begin
        refi_q[r] <= CW'(TREFI - 1 - r * STAGGER);
        debt_q[r] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      ptr_q        <= ptr_d;
      wait_q       <= wait_d;
      cmd_valid    <= valid_d;
      cmd_op       <= op_d;
      cmd_rank     <= cmd_rank_d;
      ref_fence    <= fence_d;
      ref_active   <= active_d;
      ref_overflow <= ovf_d;
      for (int r = 0; r < NUMRANK; r++) begin
        refi_q[r] <= refi_d[r];
        debt_q[r] <= debt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_channel_refresh_scheduler.sv
// Directed bench for channel_refresh_scheduler: timeline table plus hand-written corner sequences.
module tb_channel_refresh_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, refresh_en, cmd_ready, cmd_valid, ref_overflow;
  logic [1:0] rank_busy, ref_fence, ref_active, cmd_op;
  logic [0:0] cmd_rank;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  channel_refresh_scheduler #(
    .NUMRANK(2), .TREFI(100), .TRP(4), .TRFC(20), .URGENT(2), .MAXDEBT(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .refresh_en  (refresh_en),
    .rank_busy   (rank_busy),
    .ref_fence   (ref_fence),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rank    (cmd_rank),
    .ref_active  (ref_active),
    .ref_overflow(ref_overflow)
  );

  typedef struct {
    int unsigned cyc;
    logic        en;
    logic [1:0]  busy;
    logic        ready;
    logic        valid;
    logic [1:0]  op;
    logic        rank;
    logic [1:0]  active;
    logic [1:0]  fence;
  } vec_t;

  vec_t tab[15];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'b0, cmd_valid, cmd_op, cmd_rank, ref_active, ref_fence, ref_overflow};
  endfunction

  function automatic logic [31:0] pack(input logic v, input logic [1:0] op, input logic rk,
                                       input logic [1:0] act, input logic [1:0] fen,
                                       input logic ovf);
    return {23'b0, v, op, rk, act, fen, ovf};
  endfunction

  // Called #1 after a clock edge; outputs must clear before any further edge.
  task automatic do_reset(input logic en, input logic [1:0] busy, input logic rdy,
                          input string name);
    refresh_en = en;
    rank_busy  = busy;
    cmd_ready  = rdy;
    rst_n      = 1'b0;
    #1;
    check({name, "_reset_outs"}, outs(), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned cur;
    logic [31:0] act;

    // cycle, en, busy, ready | valid, op, rank, active, fence
    tab[0]  = '{99,  1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tab[1]  = '{100, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tab[2]  = '{101, 1'b1, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 2'b01};
    tab[3]  = '{102, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01};
    tab[4]  = '{105, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01};
    tab[5]  = '{106, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 2'b01};
    tab[6]  = '{107, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01};
    tab[7]  = '{126, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b01};
    tab[8]  = '{127, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tab[9]  = '{128, 1'b1, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 2'b10};
    tab[10] = '{129, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10};
    tab[11] = '{133, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10};
    tab[12] = '{134, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10};
    tab[13] = '{154, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
    tab[14] = '{201, 1'b1, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 2'b01};

    rst_n      = 1'b1;
    refresh_en = 1'b0;
    rank_busy  = 2'b00;
    cmd_ready  = 1'b0;
    #2;

    // Idle channel: rank0 then rank1 refreshed back to back.
    do_reset(1'b1, 2'b00, 1'b1, "t1");
    cur = 0;
    for (int i = 0; i < 15; i++) begin
      refresh_en = tab[i].en;
      rank_busy  = tab[i].busy;
      cmd_ready  = tab[i].ready;
      tick(int'(tab[i].cyc - cur));
      cur = tab[i].cyc;
      check($sformatf("t1_vec%0d_cyc%0d", i, tab[i].cyc), outs(),
            pack(tab[i].valid, tab[i].op, tab[i].rank, tab[i].active, tab[i].fence, 1'b0));
    end

    // Back-pressure on PREA: command held stable, REF tRP+1 after the accept.
    do_reset(1'b1, 2'b00, 1'b0, "t2");
    tick(101);
    check("t2_prea_valid", outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0));
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("t2_hold%0d", i), outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0));
    end
    cmd_ready = 1'b1;
    tick(1);
    check("t2_prea_accepted", outs(), pack(1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
    tick(3);
    check("t2_still_trp", outs(), pack(1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
    tick(1);
    check("t2_ref_valid", outs(), pack(1'b1, 2'b10, 1'b0, 2'b01, 2'b01, 1'b0));

    // Busy rank0: rank1 goes first, rank0 becomes urgent and waits for busy to drop.
    do_reset(1'b1, 2'b01, 1'b1, "t3");
    tick(101);
    check("t3_rank1_first", outs(), pack(1'b1, 2'b01, 1'b1, 2'b00, 2'b10, 1'b0));
    tick(98);
    check("t3_before_urgent", outs(), pack(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    tick(1);
    check("t3_fence_urgent", outs(), pack(1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0));
    tick(1);
    check("t3_prea_withheld", outs(), pack(1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0));
    tick(49);
    check("t3_withheld_250", outs(), pack(1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0));
    rank_busy = 2'b00;
    tick(1);
    check("t3_prea_released", outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0));
    tick(1);
    check("t3_prea_done", outs(), pack(1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
    tick(4);
    check("t3_ref_valid", outs(), pack(1'b1, 2'b10, 1'b0, 2'b01, 2'b01, 1'b0));
    tick(1);
    check("t3_ref_done", outs(), pack(1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
    tick(20);
    check("t3_debt_below_urgent", outs(), pack(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    tick(1);
    check("t3_rr_rank1", outs(), pack(1'b1, 2'b01, 1'b1, 2'b00, 2'b10, 1'b0));

    // Refresh disabled: frozen counters, no debt, no commands.
    do_reset(1'b0, 2'b00, 1'b1, "t4");
    act = '0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      act |= outs();
    end
    check("t4_quiet", act, 32'h0);
    refresh_en = 1'b1;
    tick(100);
    check("t4_no_early_cmd", outs(), 32'h0);
    tick(1);
    check("t4_first_prea", outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0));

    // Arbiter stalled: debt saturates at 3, the fourth expiry sets sticky overflow.
    do_reset(1'b1, 2'b00, 1'b0, "t5");
    tick(399);
    check("t5_before_ovf", outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b11, 1'b0));
    tick(1);
    check("t5_ovf_set", outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b11, 1'b1));
    tick(20);
    cmd_ready = 1'b1;
    tick(60);
    check("t5_ovf_sticky", 32'(ref_overflow), 32'h1);

    // Reset inside WAIT_RFC: immediate clear, fresh tREFI before the next PREA.
    do_reset(1'b1, 2'b00, 1'b1, "t6pre");
    tick(110);
    check("t6_in_rfc", outs(), pack(1'b0, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0));
    do_reset(1'b1, 2'b00, 1'b1, "t6");
    act = '0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      act |= outs();
    end
    check("t6_quiet_after_reset", act, 32'h0);
    tick(1);
    check("t6_fresh_prea", outs(), pack(1'b1, 2'b01, 1'b0, 2'b00, 2'b01, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
